spi_slave_regif: RTL

SPI_SLAVE_REGIF -- requirements
Module: spi_slave_regif

---
 rtl/spi_slave_pkg.sv | 19 +
 rtl/spi_sync_edge.sv | 40 ++++
 rtl/spi_slave_regif.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// Shared frame constants and FSM state encoding for the SPI slave register interface.
package spi_slave_pkg;

    localparam int WR_FRAME_BITS = 24;
    localparam int RD_FRAME_BITS = 16;
    localparam int HDR_BITS      = 4;
    localparam int CMD_W         = 3;
    localparam int WDATA_W       = 20;
    localparam int RDATA_W       = 12;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WR_DATA,
        RD_DATA,
        WAIT_DESEL
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI input, with rise/fall strobes
// taken from the synchronized copy.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;
    logic [STAGES:0]   warm;

    // Edges stay masked until the chain holds real samples, so a line that is
    // already low when reset releases does not look like a fresh falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
            warm  <= '0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
            warm <= {warm[STAGES-1:0], 1'b1};
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = warm[STAGES] & sync & ~prev;
    assign fall = warm[STAGES] & ~sync & prev;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave that turns write frames into register write strobes and read
// frames into a read request whose returned data is shifted back out on MISO.
module spi_slave_regif
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spi_clk,
    input  logic               spi_en_n,
    input  logic               spi_mosi,
    output logic               spi_miso,
    output logic               wr_valid,
    output logic [CMD_W-1:0]   wr_cmd,
    output logic [WDATA_W-1:0] wr_data,
    output logic               rd_req,
    output logic [CMD_W-1:0]   rd_cmd,
    input  logic [RDATA_W-1:0] rd_data,
    output logic               frame_err
);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic en_sync, en_rise, en_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk(clk), .rst_n(rst_n), .din(spi_clk),
        .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_en (
        .clk(clk), .rst_n(rst_n), .din(spi_en_n),
        .sync(en_sync), .rise(en_rise), .fall(en_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(spi_mosi),
        .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_edges = &{1'b0, sclk_sync, en_sync, mosi_rise, mosi_fall};

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [WDATA_W-2:0] sr_q, sr_d;
    logic [RDATA_W-1:0] tx_q, tx_d;
    logic [1:0]         lat_q, lat_d;
    logic [CMD_W-1:0]   pend_cmd_q, pend_cmd_d;
    logic               miso_q, miso_d;
    logic               err_seen_q, err_seen_d;
    logic               wr_valid_q, wr_valid_d;
    logic [CMD_W-1:0]   wr_cmd_q, wr_cmd_d;
    logic [WDATA_W-1:0] wr_data_q, wr_data_d;
    logic               rd_req_q, rd_req_d;
    logic [CMD_W-1:0]   rd_cmd_q, rd_cmd_d;
    logic               frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            tx_q        <= '0;
            lat_q       <= '0;
            pend_cmd_q  <= '0;
            miso_q      <= 1'b0;
            err_seen_q  <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_cmd_q    <= '0;
            wr_data_q   <= '0;
            rd_req_q    <= 1'b0;
            rd_cmd_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            tx_q        <= tx_d;
            lat_q       <= lat_d;
            pend_cmd_q  <= pend_cmd_d;
            miso_q      <= miso_d;
            err_seen_q  <= err_seen_d;
            wr_valid_q  <= wr_valid_d;
            wr_cmd_q    <= wr_cmd_d;
            wr_data_q   <= wr_data_d;
            rd_req_q    <= rd_req_d;
            rd_cmd_q    <= rd_cmd_d;
            frame_err_q <= frame_err_d;
        end
    end

    // The bit edge of this cycle is resolved first; a deselect seen in the same
    // cycle then closes whatever state that edge left the frame in.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        tx_d        = tx_q;
        lat_d       = (lat_q != 2'd0) ? lat_q - 2'd1 : 2'd0;
        pend_cmd_d  = pend_cmd_q;
        miso_d      = miso_q;
        err_seen_d  = err_seen_q;
        wr_valid_d  = 1'b0;
        wr_cmd_d    = wr_cmd_q;
        wr_data_d   = wr_data_q;
        rd_req_d    = 1'b0;
        rd_cmd_d    = rd_cmd_q;
        frame_err_d = 1'b0;

        if (lat_q == 2'd1) begin
            tx_d = rd_data;
        end

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (en_fall) begin
                    state_d = HDR;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            HDR: begin
                if (sclk_rise) begin
                    sr_d  = {sr_q[WDATA_W-3:0], mosi_s};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(HDR_BITS - 1)) begin
                        pend_cmd_d = {sr_q[1:0], mosi_s};
                        if (sr_q[2]) begin
                            state_d = WR_DATA;
                        end else begin
                            state_d  = RD_DATA;
                            rd_req_d = 1'b1;
                            rd_cmd_d = {sr_q[1:0], mosi_s};
                            lat_d    = 2'(RD_LAT);
                        end
                    end
                end
            end
            WR_DATA: begin
                if (sclk_rise) begin
                    sr_d  = {sr_q[WDATA_W-3:0], mosi_s};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(WR_FRAME_BITS - 1)) begin
                        wr_valid_d = 1'b1;
                        wr_cmd_d   = pend_cmd_q;
                        wr_data_d  = {sr_q, mosi_s};
                        state_d    = WAIT_DESEL;
                        err_seen_d = 1'b0;
                    end
                end
            end
            RD_DATA: begin
                if (sclk_fall) begin
                    miso_d = tx_d[RDATA_W-1];
                    tx_d   = {tx_d[RDATA_W-2:0], 1'b0};
                end
                if (sclk_rise) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(RD_FRAME_BITS - 1)) begin
                        state_d    = WAIT_DESEL;
                        miso_d     = 1'b0;
                        err_seen_d = 1'b0;
                    end
                end
            end
            WAIT_DESEL: begin
                miso_d = 1'b0;
                if (sclk_rise && !err_seen_q) begin
                    frame_err_d = 1'b1;
                    err_seen_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (en_rise) begin
            if (state_d inside {HDR, WR_DATA, RD_DATA}) begin
                frame_err_d = 1'b1;
            end
            state_d = IDLE;
            miso_d  = 1'b0;
        end
    end

    assign spi_miso  = miso_q;
    assign wr_valid  = wr_valid_q;
    assign wr_cmd    = wr_cmd_q;
    assign wr_data   = wr_data_q;
    assign rd_req    = rd_req_q;
    assign rd_cmd    = rd_cmd_q;
    assign frame_err = frame_err_q;

endmodule
